// File: rtl/turret_shell_launcher_pkg.sv
// Shared tank definitions: angle and launcher state enums, per-angle shell velocities, keycodes.
package tank_pkg;

  typedef enum logic [3:0] {
    ANG_0, ANG_30, ANG_45, ANG_60, ANG_90,
    ANG_270, ANG_300, ANG_315, ANG_330, ANG_NONE
  } angle_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLY,
    ST_BURST
  } launcher_state_e;

  localparam logic [7:0] KEY_FIRE = 8'h2C;
  localparam logic [7:0] KEY_UP   = 8'h1A;
  localparam logic [7:0] KEY_DOWN = 8'h16;

  localparam int VEL_W = 5;
  typedef logic signed [VEL_W-1:0] vel_t;

  // dy is in screen coordinates: negative moves the shell up the screen
  typedef struct packed {
    vel_t vx;
    vel_t dy;
  } vel_s;

  localparam vel_s VEL_0    = '{vx: 5'sd8, dy:  5'sd0};
  localparam vel_s VEL_30   = '{vx: 5'sd7, dy: -5'sd4};
  localparam vel_s VEL_45   = '{vx: 5'sd6, dy: -5'sd6};
  localparam vel_s VEL_60   = '{vx: 5'sd4, dy: -5'sd7};
  localparam vel_s VEL_90   = '{vx: 5'sd0, dy: -5'sd8};
  localparam vel_s VEL_270  = '{vx: 5'sd0, dy:  5'sd8};
  localparam vel_s VEL_300  = '{vx: 5'sd4, dy:  5'sd7};
  localparam vel_s VEL_315  = '{vx: 5'sd6, dy:  5'sd6};
  localparam vel_s VEL_330  = '{vx: 5'sd7, dy:  5'sd4};
  localparam vel_s VEL_NONE = '{vx: 5'sd0, dy:  5'sd0};

  function automatic vel_s angle_vel(angle_e a);
    case (a)
      ANG_0:   return VEL_0;
      ANG_30:  return VEL_30;
      ANG_45:  return VEL_45;
      ANG_60:  return VEL_60;
      ANG_90:  return VEL_90;
      ANG_270: return VEL_270;
      ANG_300: return VEL_300;
      ANG_315: return VEL_315;
      ANG_330: return VEL_330;
      default: return VEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/turret_shell_launcher_if.sv
// Launcher bus: keyboard/turret inputs toward the launcher, shell position/status toward the sprite mapper.
interface turret_shell_launcher_if;
  logic [7:0] keycode;
  logic       flag_t_l_0_exist;
  logic       flag_t_l_30_exist;
  logic       flag_t_l_45_exist;
  logic       flag_t_l_60_exist;
  logic       flag_t_l_90_exist;
  logic       flag_t_l_270_exist;
  logic       flag_t_l_300_exist;
  logic       flag_t_l_315_exist;
  logic       flag_t_l_330_exist;
  logic [9:0] shell_x;
  logic [9:0] shell_y;
  logic       shell_active;
  logic       shell_burst;
  logic       fire_ack;

  modport master (
    output keycode,
    output flag_t_l_0_exist, flag_t_l_30_exist, flag_t_l_45_exist,
    output flag_t_l_60_exist, flag_t_l_90_exist, flag_t_l_270_exist,
    output flag_t_l_300_exist, flag_t_l_315_exist, flag_t_l_330_exist,
    input  shell_x, shell_y, shell_active, shell_burst, fire_ack
  );

  modport slave (
    input  keycode,
    input  flag_t_l_0_exist, flag_t_l_30_exist, flag_t_l_45_exist,
    input  flag_t_l_60_exist, flag_t_l_90_exist, flag_t_l_270_exist,
    input  flag_t_l_300_exist, flag_t_l_315_exist, flag_t_l_330_exist,
    output shell_x, shell_y, shell_active, shell_burst, fire_ack
  );
endinterface

// File: rtl/turret_shell_launcher_angle_lut.sv
// Combinational turret-angle decode: nine one-hot flags to shell velocity.
// o_valid is high only when exactly one flag is set; otherwise the velocity is zero.
module shell_angle_lut
  import tank_pkg::*;
(
  input  logic [8:0] i_flags,
  output vel_t       o_vx,
  output vel_t       o_dy,
  output logic       o_valid
);

  angle_e w_angle;
  vel_s   w_vel;

  // bit order: 0,30,45,60,90,270,300,315,330 degrees
  always_comb begin
    w_angle = ANG_NONE;
    for (int i = 0; i < 9; i++) begin
      if (i_flags[i]) w_angle = angle_e'(4'(i));
    end
  end

  assign o_valid = $onehot(i_flags);
  assign w_vel   = o_valid ? angle_vel(w_angle) : VEL_NONE;
  assign o_vx    = w_vel.vx;
  assign o_dy    = w_vel.dy;

endmodule

// File: rtl/turret_shell_launcher.sv
// Single-shell launcher: fire-edge detect, launch at the muzzle, per-frame motion, burst hold, re-arm.
// Optional macro SHELL_GRAVITY_EN adds +1 to dy every 4th flight frame (saturating at +15).
module turret_shell_launcher
  import tank_pkg::*;
#(
  parameter int TURRET_X     = 100,
  parameter int TURRET_Y     = 400,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BURST_FRAMES = 8
) (
  input logic                     clk2,
  input logic                     Reset,
  turret_shell_launcher_if.slave  bus
);

  localparam int BURST_W = $clog2(BURST_FRAMES) + 1;
  localparam logic [BURST_W-1:0] BURST_LOAD = BURST_W'(BURST_FRAMES - 1);
  localparam logic [9:0]         SPAWN_X    = 10'(TURRET_X);
  localparam logic [9:0]         SPAWN_Y    = 10'(TURRET_Y);
  localparam logic signed [11:0] X_MAX      = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] Y_MAX      = 12'(SCREEN_H - 1);

  launcher_state_e    r_state;
  logic [9:0]         r_x;
  logic [9:0]         r_y;
  vel_t               r_vx;
  vel_t               r_dy;
  logic [BURST_W-1:0] r_burst_cnt;
  logic               r_fire_prev;
  logic               r_active;
  logic               r_burst;
  logic               r_fire_ack;
`ifdef SHELL_GRAVITY_EN
  logic [1:0]         r_grav_cnt;
`endif

  logic [8:0]         w_flags;
  vel_t               w_lut_vx;
  vel_t               w_lut_dy;
  logic               w_lut_valid;
  logic               w_key_fire;
  logic               w_fire_evt;
  logic signed [11:0] w_nx;
  logic signed [11:0] w_ny;
  logic               w_in_bounds;

  assign w_flags = {bus.flag_t_l_330_exist, bus.flag_t_l_315_exist, bus.flag_t_l_300_exist,
                    bus.flag_t_l_270_exist, bus.flag_t_l_90_exist,  bus.flag_t_l_60_exist,
                    bus.flag_t_l_45_exist,  bus.flag_t_l_30_exist,  bus.flag_t_l_0_exist};

  shell_angle_lut u_lut (
    .i_flags (w_flags),
    .o_vx    (w_lut_vx),
    .o_dy    (w_lut_dy),
    .o_valid (w_lut_valid)
  );

  assign w_key_fire = (bus.keycode == KEY_FIRE);
  assign w_fire_evt = w_key_fire && !r_fire_prev;

  // Next position evaluated wide and signed so underflow/overflow is caught before it is stored
  assign w_nx = signed'({2'b00, r_x}) + signed'({{7{r_vx[VEL_W-1]}}, r_vx});
  assign w_ny = signed'({2'b00, r_y}) + signed'({{7{r_dy[VEL_W-1]}}, r_dy});
  assign w_in_bounds = !w_nx[11] && (w_nx <= X_MAX) && !w_ny[11] && (w_ny <= Y_MAX);

  always_ff @(posedge clk2) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_x         <= SPAWN_X;
      r_y         <= SPAWN_Y;
      r_vx        <= '0;
      r_dy        <= '0;
      r_burst_cnt <= '0;
      r_fire_prev <= 1'b0;
      r_active    <= 1'b0;
      r_burst     <= 1'b0;
      r_fire_ack  <= 1'b0;
`ifdef SHELL_GRAVITY_EN
      r_grav_cnt  <= '0;
`endif
    end else begin
      r_fire_prev <= w_key_fire;
      r_fire_ack  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fire_evt && w_lut_valid) begin
            r_vx       <= w_lut_vx;
            r_dy       <= w_lut_dy;
            r_x        <= SPAWN_X;
            r_y        <= SPAWN_Y;
            r_fire_ack <= 1'b1;
            r_active   <= 1'b1;
            r_state    <= ST_FLY;
`ifdef SHELL_GRAVITY_EN
            r_grav_cnt <= '0;
`endif
          end
        end
        ST_FLY: begin
          if (w_in_bounds) begin
            r_x <= w_nx[9:0];
            r_y <= w_ny[9:0];
          end else begin
            r_burst_cnt <= BURST_LOAD;
            r_active    <= 1'b0;
            r_burst     <= 1'b1;
            r_state     <= ST_BURST;
          end
`ifdef SHELL_GRAVITY_EN
          r_grav_cnt <= r_grav_cnt + 2'd1;
          if (r_grav_cnt == 2'd3 && r_dy != 5'sd15) r_dy <= r_dy + 5'sd1;
`endif
        end
        ST_BURST: begin
          if (r_burst_cnt == '0) begin
            r_burst <= 1'b0;
            r_x     <= SPAWN_X;
            r_y     <= SPAWN_Y;
            r_state <= ST_IDLE;
          end else begin
            r_burst_cnt <= r_burst_cnt - BURST_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.shell_x      = r_x;
  assign bus.shell_y      = r_y;
  assign bus.shell_active = r_active;
  assign bus.shell_burst  = r_burst;
  assign bus.fire_ack     = r_fire_ack;

endmodule

// File: tb/tb_turret_shell_launcher.sv
// Directed bench for turret_shell_launcher; expected values are hand-computed from the launcher behaviour.
// With SHELL_GRAVITY_EN defined only the gravity sequence runs after reset.
module tb_turret_shell_launcher;
  logic clk2 = 1'b0;
  logic Reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cnt;
  int   both_high;
  int   acks;

  turret_shell_launcher_if bus ();

  turret_shell_launcher dut (
    .clk2  (clk2),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 clk2 = ~clk2;

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_flags(input logic [8:0] f);
    bus.flag_t_l_0_exist   = f[0];
    bus.flag_t_l_30_exist  = f[1];
    bus.flag_t_l_45_exist  = f[2];
    bus.flag_t_l_60_exist  = f[3];
    bus.flag_t_l_90_exist  = f[4];
    bus.flag_t_l_270_exist = f[5];
    bus.flag_t_l_300_exist = f[6];
    bus.flag_t_l_315_exist = f[7];
    bus.flag_t_l_330_exist = f[8];
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_x"}, 32'(bus.shell_x), 100);
    chk({tag, "_y"}, 32'(bus.shell_y), 400);
    chk({tag, "_active"}, 32'(bus.shell_active), 0);
    chk({tag, "_burst"}, 32'(bus.shell_burst), 0);
    chk({tag, "_ack"}, 32'(bus.fire_ack), 0);
  endtask

  // press fire (previous keycode assumed non-fire), launch expected on this edge
  task automatic launch(input string tag);
    bus.keycode = 8'h2C;
    tick();
    chk({tag, "_ack"}, 32'(bus.fire_ack), 1);
    chk({tag, "_active"}, 32'(bus.shell_active), 1);
    chk({tag, "_spawn_x"}, 32'(bus.shell_x), 100);
    chk({tag, "_spawn_y"}, 32'(bus.shell_y), 400);
    bus.keycode = 8'h00;
  endtask

  initial begin
    bus.keycode = 8'h00;
    set_flags(9'b0);
    repeat (3) tick();
    chk_idle("reset");
    Reset = 1'b0;
    tick();

`ifdef SHELL_GRAVITY_EN
    set_flags(9'b000000001);
    launch("grav");
    repeat (4) tick();
    chk("grav_x4", 32'(bus.shell_x), 132);
    chk("grav_y4", 32'(bus.shell_y), 400);
    tick();
    chk("grav_y5", 32'(bus.shell_y), 401);
`else
    // 45 deg flight, a second press mid-flight, then burst at the top edge
    set_flags(9'b000000100);
    launch("a45");
    tick();
    chk("a45_m1_x", 32'(bus.shell_x), 106);
    chk("a45_m1_y", 32'(bus.shell_y), 394);
    chk("a45_m1_ack", 32'(bus.fire_ack), 0);
    tick();
    chk("a45_m2_x", 32'(bus.shell_x), 112);
    chk("a45_m2_y", 32'(bus.shell_y), 388);
    tick();
    bus.keycode = 8'h2C;
    tick();
    chk("refire_ack", 32'(bus.fire_ack), 0);
    chk("refire_x", 32'(bus.shell_x), 124);
    chk("refire_y", 32'(bus.shell_y), 376);
    bus.keycode = 8'h00;
    cnt = 0;
    both_high = 0;
    while (!bus.shell_burst && cnt < 200) begin
      tick();
      cnt++;
      if (bus.shell_active && bus.shell_burst) both_high++;
    end
    chk("a45_burst_seen", 32'(bus.shell_burst), 1);
    chk("a45_burst_x", 32'(bus.shell_x), 496);
    chk("a45_burst_y", 32'(bus.shell_y), 4);
    cnt = 1;
    while (bus.shell_burst && cnt < 50) begin
      tick();
      if (bus.shell_active && bus.shell_burst) both_high++;
      if (bus.shell_burst) cnt++;
    end
    chk("a45_burst_len", 32'(cnt), 8);
    chk("act_burst_excl", 32'(both_high), 0);
    chk_idle("a45_rearm");

    // 90 deg to the top row; flags changed after launch must not matter
    set_flags(9'b000010000);
    launch("a90");
    set_flags(9'b000000001);
    for (int k = 1; k <= 50; k++) begin
      tick();
      chk("a90_y", 32'(bus.shell_y), 32'(400 - 8 * k));
      chk("a90_x", 32'(bus.shell_x), 100);
    end
    chk("a90_top_active", 32'(bus.shell_active), 1);
    tick();
    chk("a90_burst", 32'(bus.shell_burst), 1);
    chk("a90_burst_active", 32'(bus.shell_active), 0);
    chk("a90_burst_x", 32'(bus.shell_x), 100);
    chk("a90_burst_y", 32'(bus.shell_y), 0);
    repeat (7) tick();
    chk("a90_burst_last", 32'(bus.shell_burst), 1);
    chk("a90_burst_hold_y", 32'(bus.shell_y), 0);
    tick();
    chk_idle("a90_rearm");

    // 270 deg to the bottom edge
    set_flags(9'b000100000);
    launch("a270");
    repeat (9) tick();
    chk("a270_last_y", 32'(bus.shell_y), 472);
    chk("a270_last_active", 32'(bus.shell_active), 1);
    tick();
    chk("a270_burst", 32'(bus.shell_burst), 1);
    chk("a270_burst_y", 32'(bus.shell_y), 472);
    repeat (8) tick();
    chk_idle("a270_rearm");

    // fire held for 200 frames gives exactly one launch
    set_flags(9'b000000001);
    bus.keycode = 8'h2C;
    acks = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (bus.fire_ack) acks++;
    end
    chk("held_acks", 32'(acks), 1);
    chk_idle("held_end");
    bus.keycode = 8'h00;
    tick();

    // no flag, then two flags: no launch
    set_flags(9'b0);
    bus.keycode = 8'h2C;
    tick();
    chk_idle("noflag");
    bus.keycode = 8'h00;
    tick();
    set_flags(9'b000000011);
    bus.keycode = 8'h2C;
    tick();
    chk_idle("twoflag");
    bus.keycode = 8'h00;
    tick();

    // reset three frames into a 60 deg flight
    set_flags(9'b000001000);
    launch("a60");
    repeat (3) tick();
    chk("a60_x3", 32'(bus.shell_x), 112);
    chk("a60_y3", 32'(bus.shell_y), 379);
    Reset = 1'b1;
    tick();
    chk_idle("midfly_reset");
    Reset = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
